retire_unit: RTL

//  Consumer end of the ROB commit interface; sits between the ROB and the architectural state.

---
 rtl/retire_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/retire_unit.sv
// Retire unit: consumes in-order ROB commits, maintains the committed arch->phys map,
// frees superseded tags, releases committed stores and sequences exception flush/redirect.
// Optional macro RETIRE_PERF_CNT_EN adds perf_loads/perf_stores/perf_branches counters.
module retire_unit #(
  parameter int          ISSUE_W    = 2,
  parameter int          ROB_SIZE   = 16,
  parameter int          PHYS_REGS  = 64,
  parameter int          STQ_PEND   = 8,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
  localparam int         IDX_W      = $clog2(ROB_SIZE),
  localparam int         PREG_W     = $clog2(PHYS_REGS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ISSUE_W-1:0]             commit_valid,
  input  logic [ISSUE_W-1:0][4:0]        commit_arch_rd,
  input  logic [ISSUE_W-1:0][PREG_W-1:0] commit_phys_rd,
  input  logic [ISSUE_W-1:0]             commit_exception,
  input  logic [ISSUE_W-1:0]             commit_is_store,
  input  logic [ISSUE_W-1:0]             commit_is_load,
  input  logic [ISSUE_W-1:0]             commit_is_branch,
  input  logic [ISSUE_W-1:0][31:0]       commit_pc,
  output logic [ISSUE_W-1:0]             free_en,
  output logic [ISSUE_W-1:0][PREG_W-1:0] free_tag,
  output logic                           store_rel_valid,
  input  logic                           store_rel_ready,
  output logic                           flush_en,
  output logic [IDX_W-1:0]               flush_ptr,
  output logic                           redirect_valid,
  input  logic                           redirect_ready,
  output logic [31:0]                    redirect_pc,
  output logic [31:0]                    epc,
  output logic [31:0]                    instret,
  output logic                           store_ovf_err
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_loads,
  output logic [31:0]                    perf_stores,
  output logic [31:0]                    perf_branches
`endif
);

  localparam int CNT_W  = $clog2(ISSUE_W + 1);
  localparam int PEND_W = $clog2(STQ_PEND + 1);

  typedef enum logic [1:0] {RUN, FLUSH, REDIR} state_t;

  state_t                           state, state_n;
  logic [PREG_W-1:0]                amt   [32];
  logic [PREG_W-1:0]                amt_n [32];
  logic [IDX_W-1:0]                 retire_ptr;
  logic [PEND_W-1:0]                pend_cnt, pend_n;
  logic [ISSUE_W-1:0]               free_en_n;
  logic [ISSUE_W-1:0][PREG_W-1:0]   free_tag_n;
  logic [CNT_W-1:0]                 ret_cnt, consumed;
  logic                             fault, stop, pop, ovf_n;
  logic [31:0]                      epc_n;
`ifdef RETIRE_PERF_CNT_EN
  logic [CNT_W-1:0]                 ld_cnt, st_cnt, br_cnt;
`else
  logic                             unused_class_bits;
  assign unused_class_bits = ^{commit_is_load, commit_is_branch};
`endif

  function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    logic [IDX_W:0] s;
    s = {1'b0, p} + (IDX_W+1)'(n);
    if (s >= (IDX_W+1)'(ROB_SIZE)) s = s - (IDX_W+1)'(ROB_SIZE);
    return s[IDX_W-1:0];
  endfunction

  assign store_rel_valid = (pend_cnt != '0);
  assign pop             = store_rel_valid & store_rel_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_n;
  end

  always_comb begin
    state_n        = state;
    flush_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      RUN:   if (fault) state_n = FLUSH;
      FLUSH: begin
        flush_en = 1'b1;
        state_n  = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = EXC_VECTOR;
        if (redirect_ready) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Lane scan: oldest lane first, map updates visible to younger lanes in the same cycle
  always_comb begin
    amt_n      = amt;
    free_en_n  = '0;
    free_tag_n = '0;
    ret_cnt    = '0;
    consumed   = '0;
    fault      = 1'b0;
    stop       = 1'b0;
    epc_n      = epc;
    ovf_n      = store_ovf_err;
    pend_n     = pend_cnt - PEND_W'(pop);
`ifdef RETIRE_PERF_CNT_EN
    ld_cnt     = '0;
    st_cnt     = '0;
    br_cnt     = '0;
`endif
    if (state == RUN) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (!stop) begin
          if (!commit_valid[k]) begin
            stop = 1'b1;
          end else begin
            consumed = consumed + CNT_W'(1);
            if (commit_exception[k]) begin
              fault = 1'b1;
              stop  = 1'b1;
              epc_n = commit_pc[k];
            end else begin
              if (commit_arch_rd[k] != 5'd31) begin
                free_en_n[k]                = 1'b1;
                free_tag_n[k]               = amt_n[commit_arch_rd[k]];
                amt_n[commit_arch_rd[k]]    = commit_phys_rd[k];
              end
              ret_cnt = ret_cnt + CNT_W'(1);
              if (commit_is_store[k]) begin
                if (pend_n < PEND_W'(STQ_PEND)) pend_n = pend_n + PEND_W'(1);
                else                            ovf_n  = 1'b1;
              end
`ifdef RETIRE_PERF_CNT_EN
              if (commit_is_load[k])   ld_cnt = ld_cnt + CNT_W'(1);
              if (commit_is_store[k])  st_cnt = st_cnt + CNT_W'(1);
              if (commit_is_branch[k]) br_cnt = br_cnt + CNT_W'(1);
`endif
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) amt[i] <= PREG_W'(i);
      retire_ptr    <= '0;
      pend_cnt      <= '0;
      free_en       <= '0;
      free_tag      <= '0;
      flush_ptr     <= '0;
      epc           <= '0;
      instret       <= '0;
      store_ovf_err <= 1'b0;
    end else begin
      amt           <= amt_n;
      retire_ptr    <= ptr_add(retire_ptr, consumed);
      pend_cnt      <= pend_n;
      free_en       <= free_en_n;
      free_tag      <= free_tag_n;
      epc           <= epc_n;
      instret       <= instret + 32'(ret_cnt);
      store_ovf_err <= ovf_n;
      if (fault) flush_ptr <= ptr_add(retire_ptr, consumed);
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_loads    <= '0;
      perf_stores   <= '0;
      perf_branches <= '0;
    end else begin
      perf_loads    <= perf_loads    + 32'(ld_cnt);
      perf_stores   <= perf_stores   + 32'(st_cnt);
      perf_branches <= perf_branches + 32'(br_cnt);
    end
  end
`endif

endmodule
